// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-subset control unit.
// Moore FSM sequencing fetch, decode and per-class execute/writeback steps
// for lw, sw, R-type, addi, beq, bne and j. Unsupported opcodes park in HALT.
module controle_multiciclo (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] OPcode,
  input  logic [5:0] funct,
  output logic       EscreveMem,
  output logic       EscrevePC,
  output logic       EscrevePCCondEQ,
  output logic       EscrevePCCondNE,
  output logic       RegDst,
  output logic       EscreveReg,
  output logic       MemparaReg,
  output logic       IouD,
  output logic       EscreveIR,
  output logic       EscreveMDR,
  output logic       EscreveAluOut,
  output logic       OrigAALU,
  output logic [1:0] OrigPC,
  output logic [1:0] OrigBALU,
  output logic [2:0] OpALU,
  output logic [5:0] State
);

  // Opcodes and funct codes recognised by the decoder
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;

  // ALU B-input selects
  localparam logic [1:0] B_REG    = 2'b00;
  localparam logic [1:0] B_FOUR   = 2'b01;
  localparam logic [1:0] B_IMM    = 2'b10;
  localparam logic [1:0] B_IMMSH  = 2'b11;

  // ALU operation selects
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_FN   = 3'b010;

  // PC source selects
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [5:0] {
    S_RST     = 6'd0,
    S_FETCH1  = 6'd1,
    S_FETCH2  = 6'd2,
    S_DECODE  = 6'd3,
    S_MEMADDR = 6'd4,
    S_LWRD    = 6'd5,
    S_LWWAIT  = 6'd6,
    S_LWWB    = 6'd7,
    S_SW      = 6'd8,
    S_REXEC   = 6'd9,
    S_RWB     = 6'd10,
    S_BRANCH  = 6'd11,
    S_JUMP    = 6'd12,
    S_ADDIEX  = 6'd13,
    S_ADDIWB  = 6'd14,
    S_HALT    = 6'd15
  } state_t;

  state_t r_state;
  state_t w_next;

  // Raw (pre-reset-gating) control signals decoded from the state
  logic w_mem;
  logic w_pc;
  logic w_pc_eq;
  logic w_pc_ne;
  logic w_reg;
  logic w_ir;
  logic w_mdr;
  logic w_aluout;
  logic w_funct_ok;

  assign w_funct_ok = (funct == FN_ADD) || (funct == FN_SUB) ||
                      (funct == FN_AND) || (funct == FN_OR);

  // State register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: fixed sequencing plus opcode dispatch in DECODE
  always_comb begin
    w_next = S_RST;
    case (r_state)
      S_RST:    w_next = S_FETCH1;
      S_FETCH1: w_next = S_FETCH2;
      S_FETCH2: w_next = S_DECODE;
      S_DECODE: begin
        case (OPcode)
          OP_LW, OP_SW:   w_next = S_MEMADDR;
          OP_RTYPE:       w_next = w_funct_ok ? S_REXEC : S_HALT;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:           w_next = S_JUMP;
          OP_ADDI:        w_next = S_ADDIEX;
          default:        w_next = S_HALT;
        endcase
      end
      S_MEMADDR: w_next = (OPcode == OP_LW) ? S_LWRD : S_SW;
      S_LWRD:    w_next = S_LWWAIT;
      S_LWWAIT:  w_next = S_LWWB;
      S_LWWB:    w_next = S_FETCH1;
      S_SW:      w_next = S_FETCH1;
      S_REXEC:   w_next = S_RWB;
      S_RWB:     w_next = S_FETCH1;
      S_BRANCH:  w_next = S_FETCH1;
      S_JUMP:    w_next = S_FETCH1;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_ADDIWB:  w_next = S_FETCH1;
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_RST;
    endcase
  end

  // Moore output decode; only the branch-condition enables look at OPcode
  always_comb begin
    w_mem         = 1'b0;
    w_pc          = 1'b0;
    w_pc_eq       = 1'b0;
    w_pc_ne       = 1'b0;
    w_reg         = 1'b0;
    w_ir          = 1'b0;
    w_mdr         = 1'b0;
    w_aluout      = 1'b0;
    RegDst        = 1'b0;
    MemparaReg    = 1'b0;
    IouD          = 1'b0;
    OrigAALU      = 1'b0;
    OrigPC        = PC_ALU;
    OrigBALU      = B_REG;
    OpALU         = ALU_ADD;
    case (r_state)
      S_FETCH2: begin
        w_ir     = 1'b1;
        OrigBALU = B_FOUR;
        OpALU    = ALU_ADD;
        OrigPC   = PC_ALU;
        w_pc     = 1'b1;
      end
      S_DECODE: begin
        OrigBALU = B_IMMSH;
        OpALU    = ALU_ADD;
        w_aluout = 1'b1;
      end
      S_MEMADDR, S_ADDIEX: begin
        OrigAALU = 1'b1;
        OrigBALU = B_IMM;
        OpALU    = ALU_ADD;
        w_aluout = 1'b1;
      end
      S_LWRD: begin
        IouD = 1'b1;
      end
      S_LWWAIT: begin
        IouD  = 1'b1;
        w_mdr = 1'b1;
      end
      S_LWWB: begin
        MemparaReg = 1'b1;
        w_reg      = 1'b1;
      end
      S_SW: begin
        IouD  = 1'b1;
        w_mem = 1'b1;
      end
      S_REXEC: begin
        OrigAALU = 1'b1;
        OpALU    = ALU_FN;
        w_aluout = 1'b1;
      end
      S_RWB: begin
        RegDst = 1'b1;
        w_reg  = 1'b1;
      end
      S_BRANCH: begin
        OrigAALU = 1'b1;
        OpALU    = ALU_SUB;
        OrigPC   = PC_ALUOUT;
        w_pc_eq  = (OPcode == OP_BEQ);
        w_pc_ne  = (OPcode == OP_BNE);
      end
      S_JUMP: begin
        OrigPC = PC_JUMP;
        w_pc   = 1'b1;
      end
      S_ADDIWB: begin
        w_reg = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Write enables are gated combinationally by reset so an in-flight
  // store or writeback is suppressed in the very cycle reset is asserted,
  // not just from the following edge.
  assign EscreveMem      = reset & w_mem;
  assign EscrevePC       = reset & w_pc;
  assign EscrevePCCondEQ = reset & w_pc_eq;
  assign EscrevePCCondNE = reset & w_pc_ne;
  assign EscreveReg      = reset & w_reg;
  assign EscreveIR       = reset & w_ir;
  assign EscreveMDR      = reset & w_mdr;
  assign EscreveAluOut   = reset & w_aluout;

  assign State = r_state;

endmodule
